// File: rtl/aes_ch_sched.sv
// aes_ch_sched: round-robin scheduler sharing one AES core among NUM_CH channels; watchdog optional via AES_SCHED_WATCHDOG_EN
module aes_ch_sched #(
  parameter int NUM_CH  = 4,
  parameter int EN_HOLD = 51,
  parameter int TIMEOUT = 1024
) (
  input  logic                    AES_clk,
  input  logic                    AES_rst,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*128-1:0]   ch_data_in,
  input  logic [NUM_CH*128-1:0]   ch_key_in,
  output logic [NUM_CH-1:0]       ch_gnt,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [127:0]            ch_data_out,
  output logic                    core_en,
  output logic [127:0]            core_data_in,
  output logic [127:0]            core_key_in,
  input  logic [127:0]            core_data_out,
  input  logic                    core_data_out_valid,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int IW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d, done_q, done_d;
  logic en_q, en_d;
  logic [127:0] din_q, din_d, key_q, key_d, dout_q, dout_d;
  int sel;
`ifdef AES_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic to_q, to_d, terr_q, terr_d;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif
  assign ch_gnt       = gnt_q;
  assign ch_done      = done_q;
  assign ch_data_out  = dout_q;
  assign core_en      = en_q;
  assign core_data_in = din_q;
  assign core_key_in  = key_q;
  assign busy         = state_q != IDLE;
  // Arbitrate from rr_q upward and sequence one job through the shared core
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    en_d    = en_q;
    din_d   = din_q;
    key_d   = key_q;
    dout_d  = dout_q;
`ifdef AES_SCHED_WATCHDOG_EN
    wd_d    = wd_q;
    to_d    = to_q;
    terr_d  = 1'b0;
`endif
    sel = 0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (ch_req[(int'(rr_q) + k) % NUM_CH]) sel = (int'(rr_q) + k) % NUM_CH;
    case (state_q)
      IDLE: if (|ch_req) begin
        state_d    = ISSUE;
        idx_d      = IW'(sel);
        gnt_d[sel] = 1'b1;
        en_d       = 1'b1;
        cnt_d      = 8'd1;
        din_d      = ch_data_in[128*sel +: 128];
        key_d      = ch_key_in[128*sel +: 128];
`ifdef AES_SCHED_WATCHDOG_EN
        wd_d       = WW'(1);
        to_d       = 1'b0;
`endif
      end
      ISSUE, WAIT: begin
`ifdef AES_SCHED_WATCHDOG_EN
        wd_d = wd_q + 1'b1;
`endif
        if (core_data_out_valid) begin
          state_d = DONE;
          en_d    = 1'b0;
          dout_d  = core_data_out;
        end
`ifdef AES_SCHED_WATCHDOG_EN
        else if (wd_d == WW'(TIMEOUT)) begin
          state_d = DONE;
          en_d    = 1'b0;
          dout_d  = '0;
          to_d    = 1'b1;
        end
`endif
        else if (state_q == ISSUE) begin
          if (cnt_q == 8'(EN_HOLD)) begin
            state_d = WAIT;
            en_d    = 1'b0;
          end else cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d       = IDLE;
        done_d[idx_q] = 1'b1;
        rr_d          = (idx_q == IW'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
`ifdef AES_SCHED_WATCHDOG_EN
        terr_d        = to_q;
`endif
      end
    endcase
  end
  // State and registered outputs; reset aborts any job in flight
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      din_q   <= '0;
      key_q   <= '0;
      dout_q  <= '0;
`ifdef AES_SCHED_WATCHDOG_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      din_q   <= din_d;
      key_q   <= key_d;
      dout_q  <= dout_d;
`ifdef AES_SCHED_WATCHDOG_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
      terr_q  <= terr_d;
`endif
    end
  end
endmodule

// File: tb/tb_aes_ch_sched.sv
// tb_aes_ch_sched: randomized self-checking bench for aes_ch_sched with an emulated AES core; honours AES_SCHED_WATCHDOG_EN
module tb_aes_ch_sched;
  localparam int N = 4, EN_HOLD = 51, TIMEOUT = 100;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*128-1:0] data_in, key_in;
  logic [N-1:0] ch_gnt, ch_done;
  logic [127:0] ch_data_out, core_data_in, core_key_in, core_dout = '0;
  logic core_en, valid = 1'b0, busy, timeout_err;
  int total = 0, bad = 0, cyc = 0, rr_m = 0;

  aes_ch_sched #(.NUM_CH(N), .EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .AES_clk(clk), .AES_rst(rst), .ch_req(req), .ch_data_in(data_in), .ch_key_in(key_in),
    .ch_gnt(ch_gnt), .ch_done(ch_done), .ch_data_out(ch_data_out), .core_en(core_en),
    .core_data_in(core_data_in), .core_key_in(core_key_in), .core_data_out(core_dout),
    .core_data_out_valid(valid), .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d limit reached", cyc);
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int exp_grant(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_gnt();
    int n = 0;
    while (ch_gnt === '0 && n < 10) begin step(); n++; end
    if (n == 10) begin total++; bad++; $display("FAIL wait_gnt no grant within 10 cycles"); end
  endtask

  task automatic job(input logic [N-1:0] r, input logic [N-1:0] r_after, input int extra,
                     output int g, output int gcyc);
    int n, e;
    logic [127:0] xd, xk, res;
    req = r;
    e = exp_grant(r, rr_m);
    xd = data_in[128*e +: 128];
    xk = key_in[128*e +: 128];
    wait_gnt();
    g = onehot_idx(ch_gnt);
    gcyc = cyc;
    total++;
    if (ch_gnt !== 4'(1 << e)) begin bad++; $display("FAIL grant got=%b exp=%b", ch_gnt, 4'(1 << e)); end
    total++;
    if (core_data_in !== xd || core_key_in !== xk) begin bad++; $display("FAIL latch got=%h/%h exp=%h/%h", core_data_in, core_key_in, xd, xk); end
    n = 0;
    while (core_en === 1'b1 && n < 300) begin
      n++;
      step();
      if (n == 1) begin
        req = r_after;
        data_in = {rnd128(), rnd128(), rnd128(), rnd128()};
        key_in = {rnd128(), rnd128(), rnd128(), rnd128()};
        data_in[128*e +: 128] = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
        total++;
        if (ch_gnt !== '0) begin bad++; $display("FAIL gnt_pulse got=%b exp=0", ch_gnt); end
      end
    end
    total++;
    if (n != EN_HOLD) begin bad++; $display("FAIL en_hold got=%0d exp=%0d", n, EN_HOLD); end
    repeat (extra) step();
    total++;
    if (busy !== 1'b1 || ch_done !== '0) begin bad++; $display("FAIL wait_state busy=%b done=%b exp busy=1 done=0", busy, ch_done); end
    res = rnd128();
    core_dout = res;
    valid = 1'b1;
    step();
    core_dout = ~res;
    total++;
    if (ch_done !== '0 || core_en !== 1'b0 || core_data_in !== xd || core_key_in !== xk)
      begin bad++; $display("FAIL done_state done=%b en=%b din=%h key=%h exp done=0 en=0 din=%h key=%h", ch_done, core_en, core_data_in, core_key_in, xd, xk); end
    step();
    valid = 1'b0;
    total++;
    if (ch_done !== 4'(1 << e) || ch_data_out !== res || timeout_err !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL done done=%b data=%h terr=%b busy=%b exp done=%b data=%h terr=0 busy=0", ch_done, ch_data_out, timeout_err, busy, 4'(1 << e), res); end
    rr_m = (e + 1) % N;
  endtask

  task automatic check_zero(input string nm);
    total++;
    if (ch_gnt !== '0 || ch_done !== '0 || core_en !== 1'b0 || core_data_in !== '0 || core_key_in !== '0 ||
        ch_data_out !== '0 || busy !== 1'b0 || timeout_err !== 1'b0)
      begin bad++; $display("FAIL %s gnt=%b done=%b en=%b din=%h key=%h dout=%h busy=%b terr=%b exp all 0", nm, ch_gnt, ch_done, core_en, core_data_in, core_key_in, ch_data_out, busy, timeout_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1;
    core_dout = rnd128();
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    repeat (3) step();
    total++;
    if (busy !== 1'b0 || ch_done !== '0 || ch_data_out !== '0) begin bad++; $display("FAIL idle_valid busy=%b done=%b dout=%h exp 0", busy, ch_done, ch_data_out); end
    valid = 1'b0;
    rr_m = 0;
  endtask

  task automatic test_single();
    int g, gc;
    data_in[127:0] = 128'h0000000b_00000000_00000000_00000000;
    key_in[127:0] = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    job(4'b0001, 4'b0000, 3, g, gc);
    total++;
    if (g !== 0) begin bad++; $display("FAIL single_gnt got=%0d exp=0", g); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int g, gc, prev;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_m = 0;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      job(4'hF, 4'hF, 0, g, gc);
      total++;
      if (g !== order[i]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, g, order[i]); end
      if (i > 0) begin
        total++;
        if (gc - prev != EN_HOLD + 3) begin bad++; $display("FAIL rr_spacing got=%0d exp=%0d", gc - prev, EN_HOLD + 3); end
      end
      prev = gc;
    end
  endtask

  task automatic test_early_valid();
    int e;
    logic [127:0] res;
    req = 4'b0100;
    e = exp_grant(req, rr_m);
    wait_gnt();
    repeat (9) step();
    res = rnd128();
    core_dout = res;
    valid = 1'b1;
    step();
    valid = 1'b0;
    total++;
    if (core_en !== 1'b0 || ch_done !== '0 || busy !== 1'b1) begin bad++; $display("FAIL early_en en=%b done=%b busy=%b exp en=0 done=0 busy=1", core_en, ch_done, busy); end
    step();
    total++;
    if (ch_done !== 4'(1 << e) || ch_data_out !== res) begin bad++; $display("FAIL early_done done=%b data=%h exp done=%b data=%h", ch_done, ch_data_out, 4'(1 << e), res); end
    rr_m = (e + 1) % N;
  endtask

  task automatic test_drop();
    int g, gc;
    job(4'b0001, 4'b0100, 0, g, gc);
    job(4'b1000, 4'b0000, 0, g, gc);
    total++;
    if (g !== 3) begin bad++; $display("FAIL drop_gnt got=%0d exp=3", g); end
  endtask

  task automatic test_random();
    int g, gc;
    for (int i = 0; i < 20; i++) begin
      data_in = {rnd128(), rnd128(), rnd128(), rnd128()};
      key_in = {rnd128(), rnd128(), rnd128(), rnd128()};
      job(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 20), g, gc);
    end
  endtask

`ifdef AES_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int e, n;
    req = 4'b0010;
    e = exp_grant(req, rr_m);
    wait_gnt();
    req = '0;
    n = 0;
    while (ch_done === '0 && n < 200) begin step(); n++; end
    total++;
    if (n != TIMEOUT || ch_done !== 4'(1 << e) || timeout_err !== 1'b1 || ch_data_out !== '0)
      begin bad++; $display("FAIL watchdog cycles=%0d done=%b terr=%b data=%h exp cycles=%0d done=%b terr=1 data=0", n, ch_done, timeout_err, ch_data_out, TIMEOUT, 4'(1 << e)); end
    step();
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL watchdog_pulse terr=%b exp=0", timeout_err); end
    rr_m = (e + 1) % N;
  endtask
`else
  task automatic test_no_watchdog();
    logic seen = 1'b0;
    req = 4'b0010;
    wait_gnt();
    req = '0;
    repeat (300) begin
      step();
      if (ch_done !== '0 || timeout_err !== 1'b0 || busy !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL no_watchdog left WAIT got=1 exp=0"); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_m = 0;
  endtask
`endif

  task automatic test_reset_mid_job();
    int n, g, gc;
    logic seen = 1'b0;
    req = 4'b0100;
    wait_gnt();
    req = '0;
    n = 0;
    while (core_en === 1'b1 && n < 300) begin step(); n++; end
    repeat (3) step();
    rst = 1'b1;
    step();
    check_zero("reset_mid_job");
    rst = 1'b0;
    repeat (60) begin
      step();
      if (ch_done !== '0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL aborted_job activity got=1 exp=0"); end
    rr_m = 0;
    job(4'hF, 4'h0, 0, g, gc);
    total++;
    if (g !== 0) begin bad++; $display("FAIL rr_after_reset got=%0d exp=0", g); end
  endtask

  initial begin
    data_in = {rnd128(), rnd128(), rnd128(), rnd128()};
    key_in = {rnd128(), rnd128(), rnd128(), rnd128()};
    test_reset();
    test_single();
    test_round_robin();
    test_early_valid();
    test_drop();
    test_random();
`ifdef AES_SCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
